// File: rtl/hub.sv
`default_nettype none
// ============================================================================
// Module   : hub
// Purpose  : Four-port serial repeater hub. Each port hunts for an SFD and
//            captures one byte. The byte is re-framed and sent on all other ports.
// Revision : 1.0
// ============================================================================
module hub (
    input  logic clk,
    input  logic reset,
    input  logic rx0,
    input  logic rx1,
    input  logic rx2,
    input  logic rx3,
    output logic tx0,
    output logic tx1,
    output logic tx2,
    output logic tx3
);

    localparam logic [7:0] SFD     = 8'b1010_1011;
    localparam logic [0:0] RX_HUNT = 1'b0;
    localparam logic [0:0] RX_DATA = 1'b1;
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

    logic [3:0]      w_rx;
    logic [3:0]      r_rx_state;
    logic [3:0][7:0] r_shift;
    logic [3:0][2:0] r_rx_cnt;
    logic [3:0][6:0] r_rx_data;
    logic [3:0][7:0] r_pend;
    logic [3:0]      r_pend_valid;
    logic [3:0]      w_done;
    logic [3:0]      w_clr;

    logic [0:0]      r_tx_state;
    logic [3:0]      r_tx_cnt;
    logic [7:0]      r_tx_byte;
    logic [1:0]      r_tx_src;
    logic [3:0]      r_tx;
    logic [1:0]      w_sel;
    logic            w_any;
    logic            w_last;
    logic            w_load;

    // Anything other than a clean 1 (including X/Z) is sampled as 0.
    assign w_rx = {rx3 === 1'b1, rx2 === 1'b1, rx1 === 1'b1, rx0 === 1'b1};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_done[i] = (r_rx_state[i] == RX_DATA) && (r_rx_cnt[i] == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= '0;
            r_shift      <= '0;
            r_rx_cnt     <= '0;
            r_rx_data    <= '0;
            r_pend       <= '0;
            r_pend_valid <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_rx_state[i] == RX_HUNT) begin
                    r_shift[i] <= {r_shift[i][6:0], w_rx[i]};
                    if ({r_shift[i][6:0], w_rx[i]} == SFD) begin
                        r_rx_state[i] <= RX_DATA;
                        r_rx_cnt[i]   <= 3'd0;
                    end
                end else begin
                    r_rx_cnt[i] <= r_rx_cnt[i] + 3'd1;
                    if (r_rx_cnt[i] == 3'd7) begin
                        r_pend[i]     <= {w_rx[i], r_rx_data[i]};
                        r_shift[i]    <= '0;
                        r_rx_state[i] <= RX_HUNT;
                    end else begin
                        r_rx_data[i][r_rx_cnt[i]] <= w_rx[i];
                    end
                end
                // A completion in the load cycle keeps the entry valid with the new byte.
                r_pend_valid[i] <= w_done[i] | (r_pend_valid[i] & ~w_clr[i]);
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] n);
        frame_bit = n[3] ? data[n[2:0]] : SFD[~n[2:0]];
    endfunction

    function automatic logic [3:0] fanout(input logic b, input logic [1:0] src);
        fanout = {4{b}} & ~(4'b0001 << src);
    endfunction

    always_comb begin
        w_any = |r_pend_valid;
        w_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pend_valid[i]) begin
                w_sel = 2'(i);
            end
        end
        w_last = (r_tx_state == TX_SEND) && (r_tx_cnt == 4'd15);
        w_load = w_any && ((r_tx_state == TX_IDLE) || w_last);
        w_clr  = w_load ? (4'b0001 << w_sel) : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_byte  <= '0;
            r_tx_src   <= '0;
            r_tx       <= '0;
        end else if (w_load) begin
            r_tx_state <= TX_SEND;
            r_tx_cnt   <= 4'd0;
            r_tx_byte  <= r_pend[w_sel];
            r_tx_src   <= w_sel;
            r_tx       <= fanout(frame_bit(r_pend[w_sel], 4'd0), w_sel);
        end else if ((r_tx_state == TX_SEND) && !w_last) begin
            r_tx_cnt   <= r_tx_cnt + 4'd1;
            r_tx       <= fanout(frame_bit(r_tx_byte, r_tx_cnt + 4'd1), r_tx_src);
        end else begin
            r_tx_state <= TX_IDLE;
            r_tx       <= '0;
        end
    end

    assign tx0 = r_tx[0];
    assign tx1 = r_tx[1];
    assign tx2 = r_tx[2];
    assign tx3 = r_tx[3];

endmodule
`default_nettype wire

// File: tb/tb_hub.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub
// Purpose  : Directed and randomized stimulus for hub, checked every cycle
//            against a queue-based reference model of frame reception and broadcast.
// Revision : 1.0
// ============================================================================
module tb_hub;

    localparam bit [7:0] SFD_T = 8'b1010_1011;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rxv   = 4'b0000;
    logic [3:0] txv;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    hub dut (
        .clk   (clk),
        .reset (reset),
        .rx0   (rxv[0]),
        .rx1   (rxv[1]),
        .rx2   (rxv[2]),
        .rx3   (rxv[3]),
        .tx0   (txv[0]),
        .tx1   (txv[1]),
        .tx2   (txv[2]),
        .tx3   (txv[3])
    );

    always #5 clk = ~clk;

    logic     stim_q [4][$];
    bit       hist_q [4][$];
    bit       collecting [4];
    int       nd [4];
    bit [7:0] acc [4];
    bit       m_pv [4];
    bit [7:0] m_pd [4];
    int       m_pos = -1;
    int       m_src = 0;
    bit       m_bits [16];

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            hist_q[p].delete();
            collecting[p] = 1'b0;
            nd[p]         = 0;
            acc[p]        = '0;
            m_pv[p]       = 1'b0;
            m_pd[p]       = '0;
        end
        m_pos = -1;
        m_src = 0;
    endtask

    // Reference behaviour at one rising edge; the transmitter sees pending state before this edge.
    task automatic model_edge();
        int ld;
        bit b;
        bit match;
        if (!reset) begin
            model_reset();
            return;
        end
        ld = -1;
        if (m_pos < 0 || m_pos == 15) begin
            for (int p = 3; p >= 0; p--) if (m_pv[p]) ld = p;
        end
        if (ld >= 0) begin
            m_src = ld;
            for (int k = 0; k < 8; k++) begin
                m_bits[k]     = SFD_T[7-k];
                m_bits[8+k]   = m_pd[ld][k];
            end
            m_pos    = 0;
            m_pv[ld] = 1'b0;
        end else if (m_pos >= 0 && m_pos < 15) begin
            m_pos++;
        end else begin
            m_pos = -1;
        end
        for (int p = 0; p < 4; p++) begin
            b = (rxv[p] === 1'b1);
            if (!collecting[p]) begin
                hist_q[p].push_back(b);
                if (hist_q[p].size() > 8) void'(hist_q[p].pop_front());
                if (hist_q[p].size() == 8) begin
                    match = 1'b1;
                    for (int k = 0; k < 8; k++) if (hist_q[p][k] != SFD_T[7-k]) match = 1'b0;
                    if (match) begin
                        collecting[p] = 1'b1;
                        nd[p]         = 0;
                        acc[p]        = '0;
                    end
                end
            end else begin
                acc[p][nd[p]] = b;
                nd[p]++;
                if (nd[p] == 8) begin
                    m_pd[p]       = acc[p];
                    m_pv[p]       = 1'b1;
                    collecting[p] = 1'b0;
                    hist_q[p].delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit exp;
        for (int p = 0; p < 4; p++) begin
            exp = (m_pos >= 0 && p != m_src) ? m_bits[m_pos] : 1'b0;
            total++;
            assert (txv[p] === exp) else begin
                bad++;
                $error("FAIL tx%0d cyc=%0d observed=%b expected=%b", p, cyc, txv[p], exp);
            end
        end
    endtask

    task automatic step();
        for (int p = 0; p < 4; p++) begin
            if (stim_q[p].size() > 0) rxv[p] = stim_q[p].pop_front();
            else                      rxv[p] = 1'b0;
        end
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_empty();
        int guard;
        guard = 0;
        while ((stim_q[0].size() + stim_q[1].size() + stim_q[2].size() + stim_q[3].size()) > 0
               && guard < 2000) begin
            step();
            guard++;
        end
    endtask

    task automatic push_bit(input int p, input logic b);
        stim_q[p].push_back(b);
    endtask

    task automatic push_frame(input int p, input bit [7:0] data);
        for (int k = 0; k < 8; k++) push_bit(p, SFD_T[7-k]);
        for (int k = 0; k < 8; k++) push_bit(p, data[k]);
    endtask

    initial begin
        bit [7:0] ovl;
        model_reset();

        // Reset held, then idle lines with X on rx2/rx3.
        run(3);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push_bit(0, 1'b0);
            push_bit(1, 1'b0);
            push_bit(2, 1'bx);
            push_bit(3, 1'bx);
        end
        run_until_empty();
        run(5);

        // Port 0 sends 0xF0; port 1 sends 0xCC as port 0 finishes.
        push_frame(0, 8'hF0);
        run(16);
        push_frame(1, 8'hCC);
        run(60);

        // Ports 2 and 3 complete on the same edge.
        push_frame(2, 8'h5A);
        push_frame(3, 8'h3C);
        run(60);

        // SFD found on the overlapping tail of 1,0,1,0,1,0,1,0,1,1.
        ovl = 8'h96;
        push_bit(0, 1'b1); push_bit(0, 1'b0);
        for (int k = 0; k < 8; k++) push_bit(0, SFD_T[7-k]);
        for (int k = 0; k < 8; k++) push_bit(0, ovl[k]);
        run(40);

        // Asynchronous reset in the middle of a broadcast.
        push_frame(1, 8'h77);
        run(22);
        #2 reset = 1'b0;
        #1;
        total++;
        assert (txv === 4'b0000) else begin
            bad++;
            $error("FAIL async_reset observed=%b expected=%b", txv, 4'b0000);
        end
        for (int p = 0; p < 4; p++) stim_q[p].delete();
        model_reset();
        run(3);
        reset = 1'b1;
        run(40);

        // Randomized traffic, including noise and pending overwrites.
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(0, 3))
                    0: push_frame(p, 8'($urandom));
                    1: for (int k = 0; k < int'($urandom_range(1, 12)); k++) push_bit(p, 1'($urandom));
                    default: for (int k = 0; k < int'($urandom_range(0, 10)); k++) push_bit(p, 1'b0);
                endcase
            end
            run_until_empty();
            if (it % 5 == 0) run(int'($urandom_range(0, 30)));
        end
        run(120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
